// File: rtl/frame_update_scheduler.sv
// ============================================================================
// Module  : frame_update_scheduler
// Brief   : Frame-locked sequencer issuing bird/tube/collision-check steps
//           through req/ack handshakes once per VGA frame.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_update_scheduler #(
    parameter int BIRD_DIV = 4,
    parameter int TUBE_DIV = 2,
    parameter int ACK_TO   = 1024,
    parameter int FCW      = 16
) (
    input  logic           clk_50mhz,
    input  logic           rst_asyn_la,
    input  logic           enable,
    input  logic           v_sync,
    input  logic           pausa,
    input  logic           clr,
    output logic           bird_req,
    input  logic           bird_ack,
    output logic           tube_req,
    input  logic           tube_ack,
    output logic           chk_req,
    input  logic           chk_ack,
    input  logic           chk_hit,
    output logic           loose,
    output logic           overrun,
    output logic           timeout_err,
    output logic           busy,
    output logic [FCW-1:0] frame_cnt
);

    localparam int c_BIRD_W = (BIRD_DIV > 1) ? $clog2(BIRD_DIV) : 1;
    localparam int c_TUBE_W = (TUBE_DIV > 1) ? $clog2(TUBE_DIV) : 1;
    localparam int c_TO_W   = $clog2(ACK_TO);

    localparam logic [c_BIRD_W-1:0] c_BIRD_LAST = c_BIRD_W'(BIRD_DIV - 1);
    localparam logic [c_TUBE_W-1:0] c_TUBE_LAST = c_TUBE_W'(TUBE_DIV - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(ACK_TO - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BIRD = 2'd1;
    localparam logic [1:0] S_TUBE = 2'd2;
    localparam logic [1:0] S_CHK  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_v_sync_d;
    logic                r_tube_due;
    logic [c_BIRD_W-1:0] r_bird_div;
    logic [c_TUBE_W-1:0] r_tube_div;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [FCW-1:0]      r_frame_cnt;
    logic                r_loose;
    logic                r_overrun;
    logic                r_timeout_err;

    logic w_fe;
    logic w_busy;
    logic w_start;
    logic w_bird_due;
    logic w_tube_due;
    logic w_cur_ack;
    logic w_to;
    logic w_slot_done;
    logic w_hit_set;
    logic w_to_set;
    logic w_ovr_set;

    assign w_fe       = r_v_sync_d & ~v_sync;
    assign w_busy     = (r_state != S_IDLE);
    assign w_start    = ~w_busy & w_fe & enable & ~pausa;
    assign w_bird_due = (r_bird_div == c_BIRD_LAST);
    assign w_tube_due = (r_tube_div == c_TUBE_LAST);
    assign w_to       = (r_to_cnt == c_TO_LAST);

    always_comb begin
        w_cur_ack = 1'b0;
        case (r_state)
            S_BIRD:  w_cur_ack = bird_ack;
            S_TUBE:  w_cur_ack = tube_ack;
            S_CHK:   w_cur_ack = chk_ack;
            default: w_cur_ack = 1'b0;
        endcase
    end

    // A slot closes on its own ack or on timeout; acks for other slots are ignored.
    assign w_slot_done = w_busy & (w_cur_ack | w_to);
    assign w_hit_set   = enable & (r_state == S_CHK) & chk_ack & chk_hit;
    assign w_to_set    = enable & w_busy & w_to & ~w_cur_ack;
    assign w_ovr_set   = enable & w_busy & w_fe;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start)     w_state_nxt = w_bird_due ? S_BIRD : (w_tube_due ? S_TUBE : S_CHK);
            S_BIRD: if (w_slot_done) w_state_nxt = r_tube_due ? S_TUBE : S_CHK;
            S_TUBE: if (w_slot_done) w_state_nxt = S_CHK;
            S_CHK:  if (w_slot_done) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
        if (!enable) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst_asyn_la) begin
        if (!rst_asyn_la) begin
            r_state       <= S_IDLE;
            r_v_sync_d    <= 1'b1;
            r_tube_due    <= 1'b0;
            r_bird_div    <= '0;
            r_tube_div    <= '0;
            r_to_cnt      <= '0;
            r_frame_cnt   <= '0;
            r_loose       <= 1'b0;
            r_overrun     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_v_sync_d <= v_sync;

            // Per-slot ack timer restarts on every slot change.
            if (!w_busy || (w_state_nxt != r_state)) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end

            if (w_start) begin
                r_tube_due <= w_tube_due;
            end

            if (clr) begin
                r_bird_div  <= '0;
                r_tube_div  <= '0;
                r_frame_cnt <= '0;
            end else if (w_start) begin
                r_bird_div  <= w_bird_due ? '0 : r_bird_div + c_BIRD_W'(1);
                r_tube_div  <= w_tube_due ? '0 : r_tube_div + c_TUBE_W'(1);
                r_frame_cnt <= r_frame_cnt + FCW'(1);
            end

            if (w_hit_set) begin
                r_loose <= 1'b1;
            end else if (clr) begin
                r_loose <= 1'b0;
            end

            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (clr) begin
                r_overrun <= 1'b0;
            end

            if (w_to_set) begin
                r_timeout_err <= 1'b1;
            end else if (clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign bird_req    = (r_state == S_BIRD);
    assign tube_req    = (r_state == S_TUBE);
    assign chk_req     = (r_state == S_CHK);
    assign busy        = w_busy;
    assign loose       = r_loose;
    assign overrun     = r_overrun;
    assign timeout_err = r_timeout_err;
    assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_frame_update_scheduler.sv
// ============================================================================
// Module  : tb_frame_update_scheduler
// Brief   : Directed, table-driven bench for frame_update_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_update_scheduler;

    localparam int ACK_TO = 16;
    localparam int FCW    = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic           v_sync;
    logic           pausa;
    logic           clr;
    logic           bird_req, tube_req, chk_req;
    logic           bird_ack = 1'b0;
    logic           tube_ack = 1'b0;
    logic           chk_ack  = 1'b0;
    logic           chk_hit  = 1'b0;
    logic           loose, overrun, timeout_err, busy;
    logic [FCW-1:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    logic hold_b = 1'b0, hold_t = 1'b0, hold_c = 1'b0, hit_mode = 1'b0;
    logic [1:0] seq_q[$];

    typedef struct packed {
        logic        p;
        logic [5:0]  seq;
        logic [15:0] cnt;
    } vec_t;

    vec_t vt[17];

    always #5 clk = ~clk;

    frame_update_scheduler #(
        .BIRD_DIV(4),
        .TUBE_DIV(2),
        .ACK_TO  (ACK_TO),
        .FCW     (FCW)
    ) dut (
        .clk_50mhz  (clk),
        .rst_asyn_la(rst_n),
        .enable     (enable),
        .v_sync     (v_sync),
        .pausa      (pausa),
        .clr        (clr),
        .bird_req   (bird_req),
        .bird_ack   (bird_ack),
        .tube_req   (tube_req),
        .tube_ack   (tube_ack),
        .chk_req    (chk_req),
        .chk_ack    (chk_ack),
        .chk_hit    (chk_hit),
        .loose      (loose),
        .overrun    (overrun),
        .timeout_err(timeout_err),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    // Slave model: ack in the fourth cycle of a request unless withheld.
    initial begin
        int cb, ct, cc;
        cb = 0; ct = 0; cc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bird_req) begin bird_ack = (cb >= 3) && !hold_b; cb++; end
            else begin bird_ack = 1'b0; cb = 0; end
            if (tube_req) begin tube_ack = (ct >= 3) && !hold_t; ct++; end
            else begin tube_ack = 1'b0; ct = 0; end
            if (chk_req) begin chk_ack = (cc >= 3) && !hold_c; cc++; end
            else begin chk_ack = 1'b0; cc = 0; end
            chk_hit = chk_ack && hit_mode;
        end
    end

    // Records request rising edges (1=bird, 2=tube, 3=chk) and checks exclusivity.
    initial begin
        logic pb, pt, pc;
        pb = 1'b0; pt = 1'b0; pc = 1'b0;
        forever begin
            @(negedge clk);
            if (bird_req && !pb) seq_q.push_back(2'd1);
            if (tube_req && !pt) seq_q.push_back(2'd2);
            if (chk_req  && !pc) seq_q.push_back(2'd3);
            pb = bird_req; pt = tube_req; pc = chk_req;
            total++;
            if ((int'(bird_req) + int'(tube_req) + int'(chk_req)) > 1) begin
                bad++;
                $display("FAIL onehot: reqs=%b%b%b required at most one high", bird_req, tube_req, chk_req);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pack_seq();
        logic [5:0] r;
        r = 6'd0;
        if (seq_q.size() > 3) return 6'h3F;
        for (int i = 0; i < seq_q.size(); i++) r[2*i +: 2] = seq_q[i];
        return r;
    endfunction

    task automatic do_frame(input logic p);
        seq_q.delete();
        pausa  = p;
        v_sync = 1'b0;
        tick();
        tick();
        v_sync = 1'b1;
        repeat (22) tick();
        pausa = 1'b0;
    endtask

    task automatic frame_chk(input string name, input logic [5:0] seq, input logic [15:0] cnt);
        do_frame(1'b0);
        check({name, "_seq"}, 32'(pack_seq()), 32'(seq));
        check({name, "_cnt"}, 32'(frame_cnt), 32'(cnt));
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        v_sync = 1'b1;
        pausa  = 1'b0;
        clr    = 1'b0;

        // Frame-pattern table: 8 frames, 5 paused edges, 4 resumed frames.
        vt[0]  = '{p: 1'b0, seq: 6'h03, cnt: 16'd1};
        vt[1]  = '{p: 1'b0, seq: 6'h0E, cnt: 16'd2};
        vt[2]  = '{p: 1'b0, seq: 6'h03, cnt: 16'd3};
        vt[3]  = '{p: 1'b0, seq: 6'h39, cnt: 16'd4};
        vt[4]  = '{p: 1'b0, seq: 6'h03, cnt: 16'd5};
        vt[5]  = '{p: 1'b0, seq: 6'h0E, cnt: 16'd6};
        vt[6]  = '{p: 1'b0, seq: 6'h03, cnt: 16'd7};
        vt[7]  = '{p: 1'b0, seq: 6'h39, cnt: 16'd8};
        for (int i = 8; i < 13; i++) vt[i] = '{p: 1'b1, seq: 6'h00, cnt: 16'd8};
        vt[13] = '{p: 1'b0, seq: 6'h03, cnt: 16'd9};
        vt[14] = '{p: 1'b0, seq: 6'h0E, cnt: 16'd10};
        vt[15] = '{p: 1'b0, seq: 6'h03, cnt: 16'd11};
        vt[16] = '{p: 1'b0, seq: 6'h39, cnt: 16'd12};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {28'd0, bird_req, tube_req, chk_req, busy}, 32'd0);
        check("reset_flags", {29'd0, loose, overrun, timeout_err}, 32'd0);
        check("reset_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) begin
            do_frame(vt[i].p);
            check($sformatf("vec%0d_seq", i), 32'(pack_seq()), 32'(vt[i].seq));
            check($sformatf("vec%0d_cnt", i), 32'(frame_cnt), 32'(vt[i].cnt));
            check($sformatf("vec%0d_flags", i), {28'd0, loose, overrun, timeout_err, busy}, 32'd0);
        end

        // Collision: frame 13 is check-only, hit reported with the ack.
        seq_q.delete();
        hit_mode = 1'b1;
        v_sync   = 1'b0;
        tick();
        check("hit_chk_req", 32'(chk_req), 32'd1);
        tick();
        v_sync = 1'b1;
        tick();
        tick();
        check("hit_loose_before", 32'(loose), 32'd0);
        tick();
        check("hit_loose_after", 32'(loose), 32'd1);
        check("hit_chk_req_low", 32'(chk_req), 32'd0);
        hit_mode = 1'b0;
        repeat (10) tick();
        frame_chk("f14", 6'h0E, 16'd14);
        check("loose_hold1", 32'(loose), 32'd1);
        frame_chk("f15", 6'h03, 16'd15);
        check("loose_hold2", 32'(loose), 32'd1);
        frame_chk("f16", 6'h39, 16'd16);
        check("loose_hold3", 32'(loose), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_loose", 32'(loose), 32'd0);
        check("clr_cnt", 32'(frame_cnt), 32'd0);

        // Latency on the first bird-due frame after clear.
        frame_chk("lat1", 6'h03, 16'd1);
        frame_chk("lat2", 6'h0E, 16'd2);
        frame_chk("lat3", 6'h03, 16'd3);
        seq_q.delete();
        v_sync = 1'b0;
        tick();
        check("lat_bird_n1", 32'(bird_req), 32'd1);
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_cnt", 32'(frame_cnt), 32'd4);
        tick();
        v_sync = 1'b1;
        tick();
        tick();
        check("lat_bird_n4", 32'(bird_req), 32'd1);
        check("lat_tube_n4", 32'(tube_req), 32'd0);
        tick();
        check("lat_bird_n5", 32'(bird_req), 32'd0);
        check("lat_tube_n5", 32'(tube_req), 32'd1);
        repeat (20) tick();
        check("lat_seq", 32'(pack_seq()), 32'h39);

        // Timeout on the tube slot (frame 6).
        frame_chk("to5", 6'h03, 16'd5);
        hold_t = 1'b1;
        v_sync = 1'b0;
        tick();
        check("to_tube_req", 32'(tube_req), 32'd1);
        tick();
        v_sync = 1'b1;
        repeat (14) tick();
        check("to_tube_last", 32'(tube_req), 32'd1);
        check("to_err_before", 32'(timeout_err), 32'd0);
        tick();
        check("to_tube_drop", 32'(tube_req), 32'd0);
        check("to_chk_req", 32'(chk_req), 32'd1);
        check("to_err_after", 32'(timeout_err), 32'd1);
        hold_t = 1'b0;
        repeat (10) tick();
        check("to_idle", 32'(busy), 32'd0);
        check("to_loose", 32'(loose), 32'd0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_to", 32'(timeout_err), 32'd0);

        // Overrun: second frame edge while bird ack is held.
        frame_chk("ov1", 6'h03, 16'd1);
        frame_chk("ov2", 6'h0E, 16'd2);
        frame_chk("ov3", 6'h03, 16'd3);
        hold_b = 1'b1;
        v_sync = 1'b0;
        tick();
        check("ov_bird_req", 32'(bird_req), 32'd1);
        tick();
        v_sync = 1'b1;
        repeat (3) tick();
        v_sync = 1'b0;
        tick();
        check("ov_flag", 32'(overrun), 32'd1);
        check("ov_cnt", 32'(frame_cnt), 32'd4);
        tick();
        v_sync = 1'b1;
        hold_b = 1'b0;
        repeat (20) tick();
        check("ov_done", 32'(busy), 32'd0);
        check("ov_cnt_hold", 32'(frame_cnt), 32'd4);
        check("ov_no_to", 32'(timeout_err), 32'd0);
        frame_chk("ov5", 6'h03, 16'd5);
        check("ov_sticky", 32'(overrun), 32'd1);

        // Abort with enable low during the tube slot (frame 6).
        hold_t = 1'b1;
        v_sync = 1'b0;
        tick();
        check("ab_tube_req", 32'(tube_req), 32'd1);
        tick();
        v_sync = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        check("ab_tube_drop", 32'(tube_req), 32'd0);
        check("ab_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        hold_t = 1'b0;
        repeat (5) tick();
        check("ab_cnt", 32'(frame_cnt), 32'd6);
        check("ab_flags", {29'd0, loose, overrun, timeout_err}, 32'b010);

        // Asynchronous reset in the middle of a check slot (frame 7).
        hold_c = 1'b1;
        v_sync = 1'b0;
        tick();
        check("rst_chk_req", 32'(chk_req), 32'd1);
        tick();
        v_sync = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_outs", {28'd0, bird_req, tube_req, chk_req, busy}, 32'd0);
        check("arst_flags", {29'd0, loose, overrun, timeout_err}, 32'd0);
        check("arst_cnt", 32'(frame_cnt), 32'd0);
        hold_c = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("arst_idle", 32'(busy), 32'd0);
        frame_chk("post_rst", 6'h03, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
